// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the BRAM port arbiter: FSM state, owner,
// load size encoding (matches MemReadSize) and the legal store byte masks.
package mem_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;
    typedef enum logic {OWN_IF, OWN_LS} arb_owner_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [3:0] WE_LOAD = 4'b0000;
    localparam logic [3:0] WE_SB   = 4'b0001;
    localparam logic [3:0] WE_SH   = 4'b0011;
    localparam logic [3:0] WE_SW   = 4'b1111;

    // Loads are sized by ls_size, stores by their byte mask.
    function automatic logic ls_access_ok(input logic [3:0] we,
                                          input logic [1:0] size,
                                          input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (we)
            WE_LOAD: begin
                case (size)
                    SZ_B:    ok = 1'b1;
                    SZ_H:    ok = ~off[0];
                    SZ_W:    ok = (off == 2'b00);
                    default: ok = 1'b0;
                endcase
            end
            WE_SB:   ok = 1'b1;
            WE_SH:   ok = ~off[0];
            WE_SW:   ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load return path: shifts the BRAM word down to the addressed byte/half
// and zero- or sign-extends it; word accesses pass through unchanged.
module mem_load_align
    import mem_arb_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    logic [31:0] w_sh;

    assign w_sh = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_data = i_rdata;
        case (i_size)
            SZ_B:    o_data = {{24{i_signed & w_sh[7]}}, w_sh[7:0]};
            SZ_H:    o_data = {{16{i_signed & w_sh[15]}}, w_sh[15:0]};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port BRAM arbiter between fetch and load/store with store lane
// alignment and load extension. MEM_ARB_FAIRNESS_EN enables the LS burst limit.
//
// state    | meaning
// ARB_IDLE | port free, no read outstanding
// ARB_WAIT | read in flight, r_cnt counts down to the return cycle
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT  = 1,
    parameter int LS_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic [31:0] ls_addr,
    input  logic [3:0]  ls_we,
    input  logic [31:0] ls_wdata,
    input  logic [1:0]  ls_size,
    input  logic        ls_signed,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        ls_misaligned,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall
);

    localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

    arb_state_t r_state, w_state_nxt;
    arb_owner_t r_owner, w_owner_nxt;
    logic [1:0] r_cnt, w_cnt_nxt;
    logic [1:0] r_off, w_off_nxt;
    logic [1:0] r_size, w_size_nxt;
    logic       r_signed, w_signed_nxt;

    logic        w_ret, w_free, w_force_if;
    logic        w_ls_gnt, w_if_gnt, w_ls_ok;
    logic        w_ls_go, w_ls_load, w_ls_store, w_rd_gnt;
    logic [31:0] w_ld_data;
    logic        w_unused_if_lo;

    assign w_unused_if_lo = ^if_addr[1:0];

    // Grants are gated by rst_n so every output reads 0 while reset is held.
    assign w_ret    = (r_state == ARB_WAIT) && (r_cnt == 2'd0);
    assign w_free   = rst_n && ((r_state == ARB_IDLE) || w_ret);
    assign w_ls_gnt = w_free && ls_req && !w_force_if;
    assign w_if_gnt = w_free && if_req && !w_ls_gnt;

    assign w_ls_ok    = ls_access_ok(ls_we, ls_size, ls_addr[1:0]);
    assign w_ls_go    = w_ls_gnt && w_ls_ok;
    assign w_ls_load  = w_ls_go && (ls_we == WE_LOAD);
    assign w_ls_store = w_ls_go && (ls_we != WE_LOAD);
    assign w_rd_gnt   = w_if_gnt || w_ls_load;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int BW = $clog2(LS_BURST + 1);
    logic [BW-1:0] r_burst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_burst <= '0;
        else if (w_if_gnt || !if_req)
            r_burst <= '0;
        else if (w_ls_gnt)
            r_burst <= r_burst + 1'b1;
    end

    assign w_force_if = if_req && (r_burst == BW'(LS_BURST));
`else
    logic w_unused_ls_burst;
    assign w_unused_ls_burst = (LS_BURST != 0);
    assign w_force_if        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ARB_IDLE;
            r_owner  <= OWN_IF;
            r_cnt    <= 2'd0;
            r_off    <= 2'd0;
            r_size   <= SZ_B;
            r_signed <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_cnt    <= w_cnt_nxt;
            r_off    <= w_off_nxt;
            r_size   <= w_size_nxt;
            r_signed <= w_signed_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_cnt_nxt    = r_cnt;
        w_off_nxt    = r_off;
        w_size_nxt   = r_size;
        w_signed_nxt = r_signed;
        case (r_state)
            ARB_IDLE: begin
                if (w_rd_gnt)
                    w_state_nxt = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (w_ret)
                    w_state_nxt = w_rd_gnt ? ARB_WAIT : ARB_IDLE;
                else
                    w_cnt_nxt = r_cnt - 2'd1;
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
        // A new read may start in the same cycle the previous one returns.
        if (w_rd_gnt) begin
            w_cnt_nxt    = LAT_M1;
            w_owner_nxt  = w_ls_load ? OWN_LS : OWN_IF;
            w_off_nxt    = w_ls_load ? ls_addr[1:0] : 2'b00;
            w_size_nxt   = w_ls_load ? ls_size : SZ_W;
            w_signed_nxt = w_ls_load && ls_signed;
        end
    end

    mem_load_align u_load_align (
        .i_rdata  (mem_rdata),
        .i_off    (r_off),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_data   (w_ld_data)
    );

    assign if_gnt        = w_if_gnt;
    assign ls_gnt        = w_ls_gnt;
    assign ls_misaligned = w_ls_gnt && !w_ls_ok;
    assign mem_en        = w_if_gnt || w_ls_go;
    assign mem_we        = w_ls_store ? (ls_we << ls_addr[1:0]) : 4'b0000;
    assign mem_addr      = w_ls_gnt ? ls_addr[31:2] : (w_if_gnt ? if_addr[31:2] : 30'd0);

    always_comb begin
        mem_wdata = 32'd0;
        if (w_ls_store) begin
            case (ls_we)
                WE_SB:   mem_wdata = {4{ls_wdata[7:0]}};
                WE_SH:   mem_wdata = {2{ls_wdata[15:0]}};
                default: mem_wdata = ls_wdata;
            endcase
        end
    end

    assign if_rvalid = w_ret && (r_owner == OWN_IF);
    assign ls_rvalid = w_ret && (r_owner == OWN_LS);
    assign if_rdata  = if_rvalid ? mem_rdata : 32'd0;
    assign ls_rdata  = ls_rvalid ? w_ld_data : 32'd0;

    assign stall = rst_n && ((if_req && !w_if_gnt) || (ls_req && !w_ls_gnt) ||
                             ((r_state == ARB_WAIT) && !w_ret));

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported data/instruction BRAM between the fetch stage and the load/store path driven by `main_control_unit` outputs (MemRead, MemWrite byte mask, MemReadSize, MemReadSigned). It grants one transaction at a time and tracks the BRAM read latency. It aligns store lanes and extracts and extends load data. It also raises `stall` to the core while any request is unserved.

## Interface
- `MEM_LAT`, 1, BRAM read latency in cycles (1 or 2)
- `LS_BURST`, 4, max consecutive LS grants while IF waits (fairness build only)
- `clk` in 1: clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `if_req` in 1 / `if_addr` in 32: fetch request, byte address
- `if_gnt` out 1 / `if_rvalid` out 1 / `if_rdata` out 32: fetch grant, return strobe, instruction word
- `ls_req` in 1 / `ls_addr` in 32: load/store request, byte address
- `ls_we` in 4: store mask from control unit (0000 = load, 0001 SB, 0011 SH, 1111 SW)
- `ls_wdata` in 32: store data, right-justified
- `ls_size` in 2 / `ls_signed` in 1: load size (0 B, 1 H, 2 W), sign-extend flag
- `ls_gnt` out 1 / `ls_rvalid` out 1 / `ls_rdata` out 32: LS grant, load return strobe, extended load data
- `ls_misaligned` out 1: one-cycle pulse with `ls_gnt` for a rejected access
- `mem_en` out 1 / `mem_we` out 4 / `mem_addr` out 30 / `mem_wdata` out 32 / `mem_rdata` in 32: BRAM port, word address
- `stall` out 1: core stall

## Operation
- FSM states are IDLE and WAIT. A 2-bit latency counter runs in WAIT, and owner (IF/LS), byte offset, size and signed are latched at grant.
- In IDLE, or in the WAIT cycle that returns data, a grant is issued combinationally to at most one requester.
- Priority: LS wins over IF, except in the fairness build when the burst counter equals `LS_BURST` and `if_req`=1.
- IF grant: `mem_en`=1, `mem_we`=0, `mem_addr`=`if_addr[31:2]`. The low two bits are ignored; fetch is always a word access.
- LS load grant: `mem_en`=1, `mem_we`=0, and the FSM enters WAIT.
- LS store grant: `mem_en`=1 and `mem_we`=`ls_we << ls_addr[1:0]`. `mem_wdata` carries the byte replicated ×4, the half replicated ×2, or the full word. The FSM stays in IDLE and no rvalid is produced.
- Misaligned or illegal accesses are rejected. This covers a half access with addr[0]=1, a word access with addr[1:0]≠0, `ls_size`=3, or any `ls_we` outside the four legal masks. On rejection: `ls_gnt`=1, `ls_misaligned`=1, `mem_en`=0, and no rvalid.
- Load return: shift `mem_rdata` right by 8×offset, then zero- or sign-extend from bit 7 or bit 15 per the latched size/signed. A word access passes through unchanged.
- `stall` = (`if_req`&!`if_gnt`) | (`ls_req`&!`ls_gnt`) | (WAIT & no rvalid this cycle).

## Timing
- Grant is Mealy: it appears in the same cycle as the request when the port is free.
- Read data: rvalid and the data are driven in cycle grant+`MEM_LAT`, combinationally from `mem_rdata`.
- Back-to-back reads sustain one per `MEM_LAT` cycles. Stores and rejections sustain one per cycle.
- Requesters hold `req` and their operands stable until `gnt`.
- Reset values: FSM=IDLE, counters=0, and every output is 0, including the `rdata` buses and `stall`.
- Reset asserted mid-WAIT discards the read. No rvalid is produced after deassertion, even if the BRAM returns data.
- Both requesters arriving in the same cycle as an rvalid: the arbiter grants under the priority rules and the new transaction starts in that cycle.

## Configuration
- `MEM_ARB_FAIRNESS_EN` defined: the burst counter is compiled in. It increments on each LS grant while `if_req`=1, clears on an IF grant or whenever `if_req`=0, and forces an IF grant at `LS_BURST`.
- `MEM_ARB_FAIRNESS_EN` undefined: strict LS priority, the counter is absent, and `LS_BURST` is ignored.

## Structure
- `mem_arb_pkg` holds:
  - `arb_state_t` (ARB_IDLE, ARB_WAIT)
  - `arb_owner_t` (OWN_IF, OWN_LS)
  - size constants SZ_B=0, SZ_H=1, SZ_W=2, matching the MemReadSize encoding
  - the legal store mask constants
- Sub-module `mem_load_align`: combinational shift/extend taking (rdata, offset, size, signed) and producing the 32-bit result.

## Test plan
- Reset check: rst_n=0 mid-WAIT → all outputs 0. After release, no `ls_rvalid` even though `mem_rdata`=32'hDEADBEEF.
- Signed load byte: LB at addr 0x103, `mem_rdata`=32'h80_00_00_00, `MEM_LAT`=1 → `ls_gnt` in cycle 0, `ls_rvalid` in cycle 1, `ls_rdata`=32'hFFFFFF80. The same access as LBU → 32'h00000080.
- Store halfword: SH at addr 0x202, `ls_wdata`=32'h0000BEEF → `mem_we`=4'b1100, `mem_wdata`=32'hBEEFBEEF, `mem_addr`=0x80.
- Misaligned: LW at addr 0x101 → `ls_gnt`=1, `ls_misaligned`=1, `mem_en`=0, no rvalid.
- Contention: `if_req` and `ls_req` both held high with continuous loads → LS is granted first.
  - With `MEM_ARB_FAIRNESS_EN` and `LS_BURST`=4: IF is granted after exactly 4 LS grants.
  - Without the macro: IF is never granted.
- Latency: `MEM_LAT`=2 fetch at 0x40 → `if_rvalid` in cycle 2. `stall`=1 in cycle 1, and a pending LS is granted in cycle 2.
